// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning channel multiplexer.
// Scan support in the top level is gated by MUX_SCAN_N_SCAN_EN.
package mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan pointer with dwell counting and channel wrap.
// Instantiated by mux_scan_n only when MUX_SCAN_N_SCAN_EN is defined.
module mux_scan_ctr
   import mux_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DWELL    = 1,
   parameter int unsigned SEL_W    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             adv,
   output logic [SEL_W-1:0] ptr
);

   localparam int unsigned      CNT_W    = sel_width(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_cur;
   logic [SEL_W-1:0] ptr_cur;

   // The start edge already captures channel 0, so it counts as the first dwell cycle.
   always_comb begin
      cnt_cur = start ? '0 : cnt;
      ptr_cur = start ? '0 : ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ptr <= '0;
      end else if (start || adv) begin
         if (cnt_cur == CNT_LAST) begin
            cnt <= '0;
            ptr <= (ptr_cur == PTR_LAST) ? '0 : ptr_cur + 1'b1;
         end else begin
            cnt <= cnt_cur + 1'b1;
            ptr <= ptr_cur;
         end
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select and optional automatic scan.
// Define MUX_SCAN_N_SCAN_EN to build the scan FSM; otherwise mode is ignored.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DWELL    = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         mode,
   input  logic [sel_width(CHANNELS)-1:0] sel,
   input  logic [CHANNELS*WIDTH-1:0]    din,
   output logic [WIDTH-1:0]             dout,
   output logic                         dout_valid,
   output logic [sel_width(CHANNELS)-1:0] ch
);

   localparam int unsigned      SEL_W  = sel_width(CHANNELS);
   localparam logic [SEL_W:0]   CH_LIM = (SEL_W + 1)'(CHANNELS);

   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] pick;
   logic             sel_ok;

   assign sel_ok = ({1'b0, sel} < CH_LIM);

   always_comb begin
      pick = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (idx == SEL_W'(k)) pick = din[k*WIDTH +: WIDTH];
      end
   end

`ifdef MUX_SCAN_N_SCAN_EN

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             start;
   logic             adv;

   assign start = (state == IDLE) && (mode == MODE_SCAN) && en;
   assign adv   = (state == SCAN) && (mode == MODE_SCAN) && en;
   assign idx   = (mode == MODE_SCAN) ? (start ? '0 : ptr) : sel;

   mux_scan_ctr #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL),
      .SEL_W    (SEL_W)
   ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .adv   (adv),
      .ptr   (ptr)
   );

   // Leaving scan happens on the same edge that applies the manual rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dout       <= '0;
         ch         <= '0;
         dout_valid <= 1'b0;
      end else if (mode == MODE_SCAN) begin
         if (en) begin
            state      <= SCAN;
            dout       <= pick;
            ch         <= idx;
            dout_valid <= 1'b1;
         end else begin
            dout_valid <= 1'b0;
         end
      end else begin
         state <= IDLE;
         if (en && sel_ok) begin
            dout       <= pick;
            ch         <= sel;
            dout_valid <= 1'b1;
         end else begin
            dout_valid <= 1'b0;
         end
      end
   end

`else

   logic unused_mode;

   assign unused_mode = mode;
   assign idx         = sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         ch         <= '0;
         dout_valid <= 1'b0;
      end else if (en && sel_ok) begin
         dout       <= pick;
         ch         <= sel;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed self-checking bench for mux_scan_n; scan checks apply when MUX_SCAN_N_SCAN_EN is defined.
module tb_mux_scan_n;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   // A: WIDTH=1, CHANNELS=2
   logic        en_a = 1'b0, mode_a = 1'b0;
   logic [0:0]  sel_a = '0;
   logic [1:0]  din_a = '0;
   logic [0:0]  dout_a;
   logic        val_a;
   logic [0:0]  ch_a;

   // B: WIDTH=8, CHANNELS=3, DWELL=2
   logic        en_b = 1'b0, mode_b = 1'b0;
   logic [1:0]  sel_b = '0;
   logic [23:0] din_b = '0;
   logic [7:0]  dout_b;
   logic        val_b;
   logic [1:0]  ch_b;

   // C: WIDTH=8, CHANNELS=4, DWELL=1
   logic        en_c = 1'b0, mode_c = 1'b0;
   logic [1:0]  sel_c = '0;
   logic [31:0] din_c = '0;
   logic [7:0]  dout_c;
   logic        val_c;
   logic [1:0]  ch_c;

   int checks = 0;
   int failures = 0;

   mux_scan_n #(.WIDTH(1), .CHANNELS(2), .DWELL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
      .din(din_a), .dout(dout_a), .dout_valid(val_a), .ch(ch_a));

   mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
      .din(din_b), .dout(dout_b), .dout_valid(val_b), .ch(ch_b));

   mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sel(sel_c),
      .din(din_c), .dout(dout_c), .dout_valid(val_c), .ch(ch_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] b_data [3];
   int         b_seq [8];

   initial begin
      b_data = '{8'h11, 8'h22, 8'h33};
      b_seq  = '{0, 0, 1, 1, 2, 2, 0, 0};

      // asynchronous reset, observed before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_dout_a", 32'(dout_a), 0);
      check("rst_val_a",  32'(val_a),  0);
      check("rst_ch_b",   32'(ch_b),   0);
      check("rst_dout_c", 32'(dout_c), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // exhaustive registered 2:1 mux
      en_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         sel_a = v[2];
         din_a = v[1:0];
         tick();
         check("mux2_dout", 32'(dout_a), 32'(v[2] ? v[1] : v[0]));
         check("mux2_ch",   32'(ch_a),   32'(v[2]));
         check("mux2_val",  32'(val_a),  1);
      end

      // en=0 holds data and drops valid
      en_a = 1'b0;
      sel_a = 1'b0;
      din_a = 2'b00;
      tick();
      check("hold_dout_a", 32'(dout_a), 1);
      check("hold_ch_a",   32'(ch_a),   1);
      check("hold_val_a",  32'(val_a),  0);

      // mode=1 with sel=1: manual without scan build, scan start with it
      en_a = 1'b1;
      mode_a = 1'b1;
      sel_a = 1'b1;
      din_a = 2'b10;
      tick();
`ifdef MUX_SCAN_N_SCAN_EN
      check("mode1_ch_a",   32'(ch_a),   0);
      check("mode1_dout_a", 32'(dout_a), 0);
`else
      check("mode1_ch_a",   32'(ch_a),   1);
      check("mode1_dout_a", 32'(dout_a), 1);
`endif
      check("mode1_val_a", 32'(val_a), 1);
      mode_a = 1'b0;

      // invalid select holds data, drops valid
      din_b = {8'h33, 8'h22, 8'h11};
      en_b = 1'b1;
      sel_b = 2'd1;
      tick();
      check("inv_dout0", 32'(dout_b), 32'h22);
      check("inv_ch0",   32'(ch_b),   1);
      check("inv_val0",  32'(val_b),  1);
      sel_b = 2'd3;
      tick();
      check("inv_dout1", 32'(dout_b), 32'h22);
      check("inv_ch1",   32'(ch_b),   1);
      check("inv_val1",  32'(val_b),  0);

`ifdef MUX_SCAN_N_SCAN_EN
      // scan wrap with dwell 2
      mode_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("wrap_ch",   32'(ch_b),   32'(b_seq[i]));
         check("wrap_dout", 32'(dout_b), 32'(b_data[b_seq[i]]));
         check("wrap_val",  32'(val_b),  1);
      end
      // leaving scan applies manual select on that edge
      mode_b = 1'b0;
      sel_b = 2'd2;
      tick();
      check("exit_ch",   32'(ch_b),   2);
      check("exit_dout", 32'(dout_b), 32'h33);
      // re-entry restarts at channel 0
      mode_b = 1'b1;
      tick();
      check("reent_ch0", 32'(ch_b), 0);
      tick();
      check("reent_ch1", 32'(ch_b), 0);
      tick();
      check("reent_ch2", 32'(ch_b), 1);
      mode_b = 1'b0;

      // freeze during scan
      din_c = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      en_c = 1'b1;
      mode_c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_run_ch", 32'(ch_c), 32'(i));
      end
      en_c = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_ch",   32'(ch_c),   2);
         check("frz_dout", 32'(dout_c), 32'hA2);
         check("frz_val",  32'(val_c),  0);
      end
      en_c = 1'b1;
      tick();
      check("frz_next_ch",   32'(ch_c),   3);
      check("frz_next_dout", 32'(dout_c), 32'hA3);
      check("frz_next_val",  32'(val_c),  1);
      tick();
      tick();
      tick();
      check("pre_rst_ch", 32'(ch_c), 2);
`else
      // without scan, mode=1 still follows sel
      mode_b = 1'b1;
      sel_b = 2'd2;
      tick();
      check("noscan_ch_b",   32'(ch_b),   2);
      check("noscan_dout_b", 32'(dout_b), 32'h33);
      mode_b = 1'b0;

      din_c = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      en_c = 1'b1;
      mode_c = 1'b1;
      sel_c = 2'd2;
      tick();
      check("pre_rst_ch", 32'(ch_c), 2);
      sel_c = 2'd1;
`endif

      // reset between edges clears outputs immediately
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dout", 32'(dout_c), 0);
      check("mid_rst_ch",   32'(ch_c),   0);
      check("mid_rst_val",  32'(val_c),  0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
`ifdef MUX_SCAN_N_SCAN_EN
      check("post_rst_ch",   32'(ch_c),   0);
      check("post_rst_dout", 32'(dout_c), 32'hA0);
`else
      check("post_rst_ch",   32'(ch_c),   1);
      check("post_rst_dout", 32'(dout_c), 32'hA1);
`endif
      check("post_rst_val", 32'(val_c), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, meaning the data bits per channel (>=1).
REQ-002 The module SHALL have parameter CHANNELS, default 2, meaning the number of input channels (>=2).
REQ-003 The module SHALL have parameter DWELL, default 1, meaning the cycles spent on each channel in scan mode (>=1).
REQ-004 The module SHALL derive SEL_W = max(1, clog2(CHANNELS)) as a localparam.
REQ-005 The module SHALL have port clk  in  1  as the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n  in  1  as the asynchronous, active-low reset.
REQ-007 The module SHALL have port en  in  1  as the capture/advance enable.
REQ-008 The module SHALL have port mode  in  1  meaning 0 = manual select, 1 = automatic scan.
REQ-009 The module SHALL have port sel  in  SEL_W  as the manual channel select.
REQ-010 The module SHALL have port din  in  CHANNELS*WIDTH  as the flattened inputs, with channel k at bits [k*WIDTH +: WIDTH].
REQ-011 The module SHALL have port dout  out  WIDTH  as the registered selected data.
REQ-012 The module SHALL have port dout_valid  out  1  meaning dout was captured on the previous edge.
REQ-013 The module SHALL have port ch  out  SEL_W  as the index of the channel held in dout.

Function
REQ-014 The block SHALL have a latency of exactly 1 cycle: data sampled at edge N SHALL appear on dout after edge N.
REQ-015 In manual mode with en=1 and sel<CHANNELS, the block SHALL set dout<=din[sel], ch<=sel and dout_valid<=1.
REQ-016 In manual mode with en=1 and sel>=CHANNELS, the block SHALL hold dout and ch and set dout_valid<=0.
REQ-017 With en=0 in either mode, the block SHALL hold dout, ch, the scan pointer and the dwell counter, and set dout_valid<=0.
REQ-018 Scan mode SHALL use an FSM with states IDLE and SCAN.
REQ-019 The FSM SHALL transition IDLE->SCAN on the first edge with mode=1 and en=1, loading ptr=0 and cnt=0 and capturing din[0].
REQ-020 In SCAN with en=1, the block SHALL capture din[ptr], set ch<=ptr and dout_valid<=1, and increment cnt.
REQ-021 In SCAN, when cnt==DWELL-1, the block SHALL set cnt<=0 and advance ptr, wrapping CHANNELS-1 -> 0.
REQ-022 The FSM SHALL transition SCAN->IDLE on any edge with mode=0, and that edge SHALL apply the manual rule, not a scan capture.
REQ-023 Re-entering SCAN SHALL always restart at ptr=0 and cnt=0; the scan position SHALL never resume.
REQ-024 In scan mode, sel SHALL be ignored.
REQ-025 With WIDTH=1, CHANNELS=2, mode=0 and en=1, the block SHALL behave as a registered 2:1 mux: sel=0 selects din[0], sel=1 selects din[1].

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk, set dout=0, dout_valid=0, ch=0, ptr=0, cnt=0 and state=IDLE.
REQ-027 A reset asserted mid-scan SHALL abort the scan, and the first scan edge after release SHALL capture din[0].
REQ-028 Reset release SHALL be synchronous to clk by the integrating design; the block SHALL not synchronise rst_n itself.

Configuration
REQ-029 Macro MUX_SCAN_N_SCAN_EN SHALL control the scan feature.
REQ-030 With MUX_SCAN_N_SCAN_EN defined, the FSM, scan counter and all scan behaviour (REQ-018..REQ-024) SHALL be present.
REQ-031 Without MUX_SCAN_N_SCAN_EN, mode SHALL be ignored, the block SHALL always operate in manual mode, no FSM or counter SHALL be synthesised, and the port list SHALL be unchanged.

Structure
REQ-032 Shared package mux_pkg SHALL hold the state encoding (IDLE=0, SCAN=1), the mode constants (MODE_MANUAL=0, MODE_SCAN=1) and a sel-width helper function.
REQ-033 Sub-module mux_scan_ctr SHALL hold ptr/cnt with dwell and wrap logic, be instantiated only under MUX_SCAN_N_SCAN_EN, and have ports clk, rst_n, start, adv, ptr.

Verification
REQ-034 Manual exhaustive, WIDTH=1, CHANNELS=2, en=1: sweep sel, din[0], din[1] over all 8 combinations at 10 ns steps -> dout equals the selected bit one edge later, ch=sel, dout_valid=1.
REQ-035 Invalid select, CHANNELS=3, WIDTH=8, din={8'h33,8'h22,8'h11}: sel=1 then sel=3 -> dout=8'h22, ch=1, dout_valid=1; next cycle dout=8'h22, ch=1, dout_valid=0.
REQ-036 Scan wrap, CHANNELS=3, DWELL=2, mode=1, en=1 for 8 edges -> ch sequence 0,0,1,1,2,2,0,0 with dout_valid=1 throughout.
REQ-037 Freeze, DWELL=1, CHANNELS=4: scan to ch=2, en=0 for 3 cycles, then en=1 -> dout/ch hold at 2, dout_valid=0 during the pause, next capture ch=3.
REQ-038 Async reset mid-scan: drop rst_n between edges while ch=2 -> outputs go to 0 before the next edge; after release the first capture is ch=0.
REQ-039 Build without MUX_SCAN_N_SCAN_EN, mode=1, sel=1 -> manual behaviour, ch=1.
